// File: rtl/conv_pool_relu.sv
// conv_pool_relu: reads conv partial sums, applies 2x2/stride-2 max pooling,
// ReLU, arithmetic right shift and unsigned saturation, then writes activations.
// Ports: clk, reset (sync active-low), start pulse; in_req/in_addr/in_data
// read side (1-cycle latency); out_req/out_addr/out_data write side;
// busy level and one-cycle finish pulse. All outputs are registered.
module conv_pool_relu #(
    parameter int DATA_WIDTH     = 20,
    parameter int IN_ADDR_WIDTH  = 10,
    parameter int OUT_WIDTH      = 8,
    parameter int OUT_ADDR_WIDTH = 10,
    parameter int MAP_W          = 30,
    parameter int MAP_H          = 30,
    parameter int SHIFT          = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      in_req,
    output logic [IN_ADDR_WIDTH-1:0]  in_addr,
    input  logic [DATA_WIDTH-1:0]     in_data,
    output logic                      out_req,
    output logic [OUT_ADDR_WIDTH-1:0] out_addr,
    output logic [OUT_WIDTH-1:0]      out_data,
    output logic                      busy,
    output logic                      finish
);

    localparam int PW = MAP_W / 2;
    localparam int PH = MAP_H / 2;
    localparam int CW = (PW > 1) ? $clog2(PW) : 1;
    localparam int RW = (PH > 1) ? $clog2(PH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_e;

    state_e                    state_q;
    logic [RW-1:0]             r_q;
    logic [CW-1:0]             c_q;
    logic [1:0]                k_q;
    logic [DATA_WIDTH-1:0]     max_q;
    logic [DATA_WIDTH-1:0]     max_d;
    logic                      in_req_q;
    logic [IN_ADDR_WIDTH-1:0]  in_addr_q;
    logic                      out_req_q;
    logic [OUT_ADDR_WIDTH-1:0] out_addr_q;
    logic [OUT_WIDTH-1:0]      out_data_q;
    logic                      busy_q;
    logic                      finish_q;
    logic                      last_c;
    logic                      last_r;

    function automatic logic [IN_ADDR_WIDTH-1:0] rd_addr(
        input logic [RW-1:0] r,
        input logic [CW-1:0] c,
        input logic [1:0]    k
    );
        logic [31:0] a;
        a = 32'(r) * 32'(2 * MAP_W) + 32'(c) * 32'd2
          + (k[1] ? 32'(MAP_W) : 32'd0) + {31'd0, k[0]};
        return a[IN_ADDR_WIDTH-1:0];
    endfunction

    function automatic logic [OUT_ADDR_WIDTH-1:0] wr_addr(
        input logic [RW-1:0] r,
        input logic [CW-1:0] c
    );
        logic [31:0] a;
        a = 32'(r) * 32'(PW) + 32'(c);
        return a[OUT_ADDR_WIDTH-1:0];
    endfunction

    // Negative -> 0; the shift then acts on a non-negative value, so a
    // logical shift equals the arithmetic one.
    function automatic logic [OUT_WIDTH-1:0] relu_sat(
        input logic [DATA_WIDTH-1:0] m
    );
        logic [DATA_WIDTH-1:0] sh;
        sh = m >> SHIFT;
        if (m[DATA_WIDTH-1]) return '0;
        if ((sh >> OUT_WIDTH) != '0) return '1;
        return sh[OUT_WIDTH-1:0];
    endfunction

    // In READ with k=1 the first datum of the window arrives and loads
    // unconditionally; later data replace it only when strictly greater.
    always_comb begin
        max_d = max_q;
        if ((state_q == S_READ && k_q == 2'd1)
            || ($signed(in_data) > $signed(max_q)))
            max_d = in_data;
    end

    assign last_c = (c_q == CW'(PW - 1));
    assign last_r = (r_q == RW'(PH - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            r_q        <= '0;
            c_q        <= '0;
            k_q        <= '0;
            max_q      <= '0;
            in_req_q   <= 1'b0;
            in_addr_q  <= '0;
            out_req_q  <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
            busy_q     <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_READ;
                        r_q       <= '0;
                        c_q       <= '0;
                        k_q       <= '0;
                        in_req_q  <= 1'b1;
                        in_addr_q <= rd_addr('0, '0, 2'd0);
                        busy_q    <= 1'b1;
                    end
                end
                S_READ: begin
                    if (k_q != 2'd0) max_q <= max_d;
                    if (k_q == 2'd3) begin
                        state_q  <= S_WAIT;
                        k_q      <= '0;
                        in_req_q <= 1'b0;
                    end else begin
                        k_q       <= k_q + 2'd1;
                        in_addr_q <= rd_addr(r_q, c_q, k_q + 2'd1);
                    end
                end
                S_WAIT: begin
                    state_q    <= S_WRITE;
                    max_q      <= max_d;
                    out_req_q  <= 1'b1;
                    out_addr_q <= wr_addr(r_q, c_q);
                    out_data_q <= relu_sat(max_d);
                end
                S_WRITE: begin
                    out_req_q <= 1'b0;
                    if (last_c && last_r) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        finish_q <= 1'b1;
                    end else if (last_c) begin
                        state_q   <= S_READ;
                        c_q       <= '0;
                        r_q       <= r_q + RW'(1);
                        in_req_q  <= 1'b1;
                        in_addr_q <= rd_addr(r_q + RW'(1), '0, 2'd0);
                    end else begin
                        state_q   <= S_READ;
                        c_q       <= c_q + CW'(1);
                        in_req_q  <= 1'b1;
                        in_addr_q <= rd_addr(r_q, c_q + CW'(1), 2'd0);
                    end
                end
                S_DONE: begin
                    state_q  <= S_IDLE;
                    finish_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_req   = in_req_q;
    assign in_addr  = in_addr_q;
    assign out_req  = out_req_q;
    assign out_addr = out_addr_q;
    assign out_data = out_data_q;
    assign busy     = busy_q;
    assign finish   = finish_q;

endmodule

// File: tb/tb_conv_pool_relu.sv
// tb_conv_pool_relu: directed bench for conv_pool_relu on a 4x4 map.
// Models the conv SRAM with 1-cycle read latency and checks writes/timing.
module tb_conv_pool_relu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_req;
    logic [9:0]  in_addr;
    logic [19:0] in_data;
    logic        out_req;
    logic [9:0]  out_addr;
    logic [7:0]  out_data;
    logic        busy;
    logic        finish;

    logic [19:0] mem [16];

    int checks = 0;
    int fails  = 0;

    int          wa[$];
    int          wd[$];
    int          wc[$];
    int          fin_n;
    int          fin_c;
    int          both;
    int          post;
    logic        busy_fin;
    logic [1:0]  req1;
    logic [9:0]  addr1;
    logic [31:0] snap;

    conv_pool_relu #(
        .DATA_WIDTH(20), .IN_ADDR_WIDTH(10), .OUT_WIDTH(8),
        .OUT_ADDR_WIDTH(10), .MAP_W(4), .MAP_H(4), .SHIFT(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_req(in_req), .in_addr(in_addr), .in_data(in_data),
        .out_req(out_req), .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .finish(finish)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk)
        if (in_req) in_data <= mem[in_addr[3:0]];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulses start in cycle 0 and observes cycles 1..40 at the negedge.
    task automatic run_pass(input int extra_start, input int rst_at);
        wa.delete(); wd.delete(); wc.delete();
        fin_n = 0; fin_c = -1; both = 0; post = 0;
        busy_fin = 1'b1; snap = '1; req1 = '0; addr1 = '1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (out_req) begin
                wa.push_back(int'(out_addr));
                wd.push_back(int'(out_data));
                wc.push_back(cyc);
            end
            if (finish) begin
                fin_n++;
                fin_c = cyc;
                busy_fin = busy;
            end
            if (in_req && out_req) both++;
            if (cyc == 1) begin
                req1  = {busy, in_req};
                addr1 = in_addr;
            end
            if (rst_at > 0 && cyc == rst_at + 1)
                snap = {in_req, out_req, busy, finish,
                        in_addr, out_addr, out_data};
            if (rst_at > 0 && cyc > rst_at && (in_req || out_req))
                post++;
            start = (cyc == extra_start);
            reset = !(cyc == rst_at);
            @(negedge clk);
        end
        start = 1'b0;
        reset = 1'b1;
    endtask

    task automatic check_pass(input string p, input int ed [4]);
        check({p, ":first_req"}, 32'(req1), 32'h3);
        check({p, ":first_addr"}, 32'(addr1), 32'd0);
        check({p, ":nwrites"}, wa.size(), 4);
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            check($sformatf("%s:waddr%0d", p, i), wa[i], i);
            check($sformatf("%s:wdata%0d", p, i), wd[i], ed[i]);
            check($sformatf("%s:wcyc%0d", p, i), wc[i], 6 * (i + 1));
        end
        check({p, ":fin_n"}, fin_n, 1);
        check({p, ":fin_cyc"}, fin_c, 25);
        check({p, ":busy_at_fin"}, 32'(busy_fin), 0);
        check({p, ":req_overlap"}, both, 0);
    endtask

    initial begin
        int ramp[4];
        int edge_exp[4];
        ramp     = '{5, 7, 13, 15};
        edge_exp = '{0, 255, 18, 1};
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 20'(i * 256);
        repeat (3) @(negedge clk);
        check("rst_outputs",
              {in_req, out_req, busy, finish, in_addr, out_addr, out_data},
              32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_pass(0, 0);
        check_pass("ramp", ramp);

        mem[0]  = 20'hFFFFF; mem[1]  = 20'h80000;
        mem[4]  = 20'hFFF00; mem[5]  = 20'hC0000;
        mem[2]  = 20'h00000; mem[3]  = 20'h00000;
        mem[6]  = 20'h00000; mem[7]  = 20'h7FFFF;
        mem[8]  = 20'h00010; mem[9]  = 20'hFFFFF;
        mem[12] = 20'h01234; mem[13] = 20'h00200;
        mem[10] = 20'h00100; mem[11] = 20'h00100;
        mem[14] = 20'hFFFFF; mem[15] = 20'h00050;
        run_pass(0, 0);
        check_pass("edge", edge_exp);

        for (int i = 0; i < 16; i++) mem[i] = 20'(i * 256);
        run_pass(10, 0);
        check_pass("restart", ramp);

        run_pass(0, 8);
        check("rst8:outputs", snap, 32'd0);
        check("rst8:post_strobes", post, 0);
        check("rst8:fin_n", fin_n, 0);
        check("rst8:nwrites", wa.size(), 1);

        run_pass(0, 0);
        check_pass("after_rst", ramp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
